// File: rtl/rc_capture_array.sv
// N-channel RC PWM capture: measures pulse high time in us_clk cycles, scales it to a
// command value, rejects glitches, times out lost channels and tracks complete frames.

module rc_capture_lane #(
  parameter int unsigned VAL_BIT_WIDTH = 8,
  parameter int unsigned MIN_PULSE_US  = 1000,
  parameter int unsigned SCALE_SHIFT   = 2,
  parameter int unsigned GLITCH_MIN_US = 800,
  parameter int unsigned GLITCH_MAX_US = 2500,
  parameter int unsigned TIMEOUT_US    = 25000,
  parameter int unsigned FAILSAFE_VAL  = 0
) (
  input  logic                     us_clk,
  input  logic                     rst_n,
  input  logic                     pwm,
  output logic [VAL_BIT_WIDTH-1:0] val,
  output logic                     good,
  output logic                     good_nxt,
  output logic                     strobe,
  output logic                     acc,
  output logic                     tmo
);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

  localparam logic [31:0] VMAX = (32'd1 << VAL_BIT_WIDTH) - 32'd1;

  state_t                   state, state_nxt;
  logic                     s1, s2, hist, rise, fall, done, hit;
  logic [15:0]              wcnt, to_cnt, to_nxt;
  logic [31:0]              c32, v32;
  logic [VAL_BIT_WIDTH-1:0] scaled;

  // Synchroniser resets high so a pulse already in progress at reset release
  // never looks like a low and cannot arm the channel.
  always_ff @(posedge us_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      hist <= 1'b1;
    end else begin
      s1   <= pwm;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign rise = s2 & ~hist;
  assign fall = ~s2 & hist;

  always_ff @(posedge us_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!s2) state_nxt = WAIT_RISE;
      WAIT_RISE: if (rise) state_nxt = MEASURE;
      MEASURE:   if (fall) state_nxt = WAIT_RISE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = (state == MEASURE) && fall;
    acc  = done && (wcnt >= 16'(GLITCH_MIN_US)) && (wcnt <= 16'(GLITCH_MAX_US));
  end

  always_ff @(posedge us_clk or negedge rst_n) begin
    if (!rst_n)                          wcnt <= '0;
    else if (state == WAIT_RISE && rise) wcnt <= 16'd1;
    else if (state == MEASURE && s2 && wcnt != 16'hFFFF) wcnt <= wcnt + 16'd1;
  end

  always_comb begin
    c32    = ({16'd0, wcnt} < MIN_PULSE_US) ? MIN_PULSE_US : {16'd0, wcnt};
    v32    = (c32 - MIN_PULSE_US) >> SCALE_SHIFT;
    scaled = (v32 > VMAX) ? VMAX[VAL_BIT_WIDTH-1:0] : v32[VAL_BIT_WIDTH-1:0];
  end

  // An accept on the threshold cycle wins over the timeout.
  assign to_nxt   = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
  assign hit      = (to_nxt == 16'(TIMEOUT_US));
  assign tmo      = hit & ~acc;
  assign good_nxt = acc | (good & ~hit);

  always_ff @(posedge us_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      val    <= VAL_BIT_WIDTH'(FAILSAFE_VAL);
      good   <= 1'b0;
      strobe <= 1'b0;
    end else begin
      to_cnt <= acc ? 16'd0 : to_nxt;
      if (acc)      val <= scaled;
      else if (hit) val <= VAL_BIT_WIDTH'(FAILSAFE_VAL);
      good   <= good_nxt;
      strobe <= acc;
    end
  end
endmodule

module rc_capture_array #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned VAL_BIT_WIDTH = 8,
  parameter int unsigned MIN_PULSE_US  = 1000,
  parameter int unsigned SCALE_SHIFT   = 2,
  parameter int unsigned GLITCH_MIN_US = 800,
  parameter int unsigned GLITCH_MAX_US = 2500,
  parameter int unsigned TIMEOUT_US    = 25000,
  parameter int unsigned FAILSAFE_VAL  = 0
) (
  input  logic                                   us_clk,
  input  logic                                   resetn,
  input  logic [NUM_CHANNELS-1:0]                pwm_in,
  output logic [NUM_CHANNELS*VAL_BIT_WIDTH-1:0]  val_out,
  output logic [NUM_CHANNELS-1:0]                channel_good,
  output logic                                   all_good,
  output logic [NUM_CHANNELS-1:0]                update_strobe,
  output logic                                   frame_strobe
);
  logic [1:0]                                   rst_q;
  logic                                         rst_n;
  logic [NUM_CHANNELS-1:0][VAL_BIT_WIDTH-1:0]   vals;
  logic [NUM_CHANNELS-1:0]                      acc, tmo, good_nxt, seen, seen_set;

  // Async assert, release aligned to us_clk.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) rst_q <= 2'b00;
    else         rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    rc_capture_lane #(
      .VAL_BIT_WIDTH(VAL_BIT_WIDTH), .MIN_PULSE_US(MIN_PULSE_US), .SCALE_SHIFT(SCALE_SHIFT),
      .GLITCH_MIN_US(GLITCH_MIN_US), .GLITCH_MAX_US(GLITCH_MAX_US),
      .TIMEOUT_US(TIMEOUT_US), .FAILSAFE_VAL(FAILSAFE_VAL)
    ) u_lane (
      .us_clk   (us_clk),
      .rst_n    (rst_n),
      .pwm      (pwm_in[g]),
      .val      (vals[g]),
      .good     (channel_good[g]),
      .good_nxt (good_nxt[g]),
      .strobe   (update_strobe[g]),
      .acc      (acc[g]),
      .tmo      (tmo[g])
    );
  end

  assign val_out  = vals;
  assign seen_set = seen | acc;

  // Frame completes on the same edge that registers the last channel's strobe.
  always_ff @(posedge us_clk or negedge rst_n) begin
    if (!rst_n) begin
      seen         <= '0;
      frame_strobe <= 1'b0;
      all_good     <= 1'b0;
    end else begin
      all_good <= &good_nxt;
      if (&seen_set) begin
        seen         <= '0;
        frame_strobe <= 1'b1;
      end else begin
        seen         <= seen_set & ~tmo;
        frame_strobe <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rc_capture_array.sv
// Bench for rc_capture_array: table vectors, directed frame/timeout/reset sequences and
// random pulses, all checked against a pulse-level reference model.

module tb_rc_capture_array;
  localparam int NC = 4;
  localparam int W  = 8;
  localparam int T  = 25000;

  logic              us_clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NC-1:0]     pwm_in = '0;
  logic [NC*W-1:0]   val_out;
  logic [NC-1:0]     channel_good, update_strobe;
  logic              all_good, frame_strobe;

  rc_capture_array #(.NUM_CHANNELS(NC), .VAL_BIT_WIDTH(W)) dut (
    .us_clk        (us_clk),
    .resetn        (resetn),
    .pwm_in        (pwm_in),
    .val_out       (val_out),
    .channel_good  (channel_good),
    .all_good      (all_good),
    .update_strobe (update_strobe),
    .frame_strobe  (frame_strobe)
  );

  always #5 us_clk = ~us_clk;

  int cyc = 0;
  int scnt = 0;
  int fcnt = 0;
  always @(posedge us_clk) begin
    cyc  <= cyc + 1;
    scnt <= scnt + int'(|update_strobe);
    fcnt <= fcnt + int'(frame_strobe);
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: last accepted value, accept cycle and frame bookkeeping per channel.
  int            val_m[NC];
  int            last_m[NC];
  bit            ever_m[NC];
  logic [NC-1:0] seen_m;

  function automatic int model_val(int w);
    int c, v;
    c = (w < 1000) ? 1000 : w;
    v = (c - 1000) / 4;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic bit model_acc(int w);
    return (w >= 800) && (w <= 2500);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      val_m[i] = 0; last_m[i] = 0; ever_m[i] = 0;
    end
    seen_m = '0;
  endtask

  task automatic check_state(input int c);
    bit g, g_all;
    g_all = 1;
    for (int i = 0; i < NC; i++) begin
      g = ever_m[i] && (c - last_m[i] < T);
      chk($sformatf("channel_good[%0d]", i), int'(channel_good[i]), int'(g));
      chk($sformatf("val_out[%0d]", i), int'(val_out[i*W +: W]), g ? val_m[i] : 0);
      g_all &= g;
    end
    chk("all_good", int'(all_good), int'(g_all));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(negedge us_clk);
    resetn = 1'b1;
    model_reset();
    repeat (4) @(negedge us_clk);
  endtask

  task automatic pulse(input logic [NC-1:0] m, input int w, output logic [NC-1:0] obs);
    logic [NC-1:0] exp_s;
    bit exp_f;
    int c;
    @(negedge us_clk);
    pwm_in = pwm_in | m;
    repeat (w) @(negedge us_clk);
    pwm_in = pwm_in & ~m;
    repeat (2) @(negedge us_clk);
    chk("strobe_early", int'(update_strobe), 0);
    @(negedge us_clk);
    c = cyc;
    exp_s = model_acc(w) ? m : '0;
    for (int i = 0; i < NC; i++)
      if (seen_m[i] && c > last_m[i] + T) seen_m[i] = 1'b0;
    for (int i = 0; i < NC; i++)
      if (exp_s[i]) begin
        val_m[i] = model_val(w); last_m[i] = c; ever_m[i] = 1;
      end
    seen_m = seen_m | exp_s;
    exp_f  = &seen_m;
    if (exp_f) seen_m = '0;
    obs = update_strobe;
    chk("update_strobe", int'(update_strobe), int'(exp_s));
    chk("frame_strobe", int'(frame_strobe), int'(exp_f));
    check_state(c);
    @(negedge us_clk);
    chk("strobe_one_cycle", int'(update_strobe), 0);
    chk("frame_one_cycle", int'(frame_strobe), 0);
    repeat (3) @(negedge us_clk);
  endtask

  typedef struct {
    int ch;
    int width;
    int exp_val;
    bit exp_acc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] m, obs;
    int w, f0, s0, t0;

    tbl[0]  = '{0, 1500, 125, 1};
    tbl[1]  = '{1,  900,   0, 1};
    tbl[2]  = '{1, 2000, 250, 1};
    tbl[3]  = '{1, 2100, 255, 1};
    tbl[4]  = '{2, 1500, 125, 1};
    tbl[5]  = '{2,  700, 125, 0};
    tbl[6]  = '{2, 2600, 125, 0};
    tbl[7]  = '{3,  800,   0, 1};
    tbl[8]  = '{3, 2500, 255, 1};
    tbl[9]  = '{0,  799, 125, 0};
    tbl[10] = '{0, 2501, 125, 0};
    tbl[11] = '{0, 1003,   0, 1};
    tbl[12] = '{0, 1004,   1, 1};

    // Reset state
    model_reset();
    repeat (4) @(negedge us_clk);
    chk("reset_val_out", int'(val_out), 0);
    chk("reset_channel_good", int'(channel_good), 0);
    chk("reset_all_good", int'(all_good), 0);
    chk("reset_update_strobe", int'(update_strobe), 0);
    chk("reset_frame_strobe", int'(frame_strobe), 0);
    resetn = 1'b1;
    repeat (4) @(negedge us_clk);

    for (int k = 0; k < 13; k++) begin
      m = '0;
      m[tbl[k].ch] = 1'b1;
      pulse(m, tbl[k].width, obs);
      chk($sformatf("tbl%0d_strobe", k), int'(obs[tbl[k].ch]), int'(tbl[k].exp_acc));
      chk($sformatf("tbl%0d_val", k), int'(val_out[tbl[k].ch*W +: W]), tbl[k].exp_val);
    end

    // Staggered updates complete exactly one frame; a lone extra update does not.
    do_reset();
    f0 = fcnt;
    pulse(4'b0100, 1500, obs);
    pulse(4'b0001, 1500, obs);
    pulse(4'b1000, 1500, obs);
    pulse(4'b0010, 1500, obs);
    chk("frame_count_staggered", fcnt - f0, 1);
    pulse(4'b0001, 1500, obs);
    chk("frame_count_extra", fcnt - f0, 1);
    pulse(4'b1111, 1500, obs);
    chk("frame_count_simultaneous", fcnt - f0, 2);

    // ch3 goes silent: lost exactly TIMEOUT cycles after its last accept.
    pulse(4'b0111, 1500, obs);
    t0 = -1;
    for (int k = 0; k < 30000; k++) begin
      @(negedge us_clk);
      if (!channel_good[3]) begin
        t0 = cyc;
        break;
      end
    end
    chk("timeout_cycles", t0 - last_m[3], T);
    chk("timeout_good_mask", int'(channel_good), 4'b0111);
    chk("timeout_all_good", int'(all_good), 0);
    chk("timeout_val3", int'(val_out[31:24]), 0);
    chk("timeout_val0", int'(val_out[7:0]), 125);
    pulse(4'b1000, 1500, obs);
    chk("restore_good3", int'(channel_good[3]), 1);
    chk("restore_val3", int'(val_out[31:24]), 125);

    // Reset in the middle of a pulse: that pulse is never measured.
    @(negedge us_clk);
    pwm_in[0] = 1'b1;
    repeat (700) @(negedge us_clk);
    resetn = 1'b0;
    repeat (3) @(negedge us_clk);
    chk("midreset_val_out", int'(val_out), 0);
    chk("midreset_good", int'(channel_good), 0);
    chk("midreset_strobe", int'(update_strobe), 0);
    resetn = 1'b1;
    model_reset();
    s0 = scnt;
    repeat (800) @(negedge us_clk);
    pwm_in[0] = 1'b0;
    repeat (10) @(negedge us_clk);
    chk("midreset_pulse_ignored", scnt - s0, 0);
    chk("midreset_val0_failsafe", int'(val_out[7:0]), 0);
    chk("midreset_good0", int'(channel_good[0]), 0);
    pulse(4'b0001, 1500, obs);
    chk("after_reset_val0", int'(val_out[7:0]), 125);

    // Random channel masks and widths around the glitch and clamp limits.
    for (int k = 0; k < 10; k++) begin
      m = NC'($urandom_range(1, 15));
      w = $urandom_range(700, 2600);
      pulse(m, w, obs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rc_capture_array.md
Name: rc_capture_array

Overview:
Parametrised N-channel RC receiver capture block that replaces the fixed four-channel receiver.
- Measures the high time of each RC PWM input in microseconds and scales it to a VAL_BIT_WIDTH command value.
- Rejects glitch pulses, detects per-channel signal loss, and forces failsafe values on lost channels.
- Emits per-channel and whole-frame update strobes.
- Sits between the RC pins and angle_controller, clocked from the us_clk divider output.

Parameters:
NUM_CHANNELS, 4, number of independent PWM inputs
VAL_BIT_WIDTH, 8, output value width per channel
MIN_PULSE_US, 1000, pulse width mapping to value 0
SCALE_SHIFT, 2, right shift applied to (width - MIN_PULSE_US)
GLITCH_MIN_US, 800, pulses shorter than this are rejected
GLITCH_MAX_US, 2500, pulses longer than this are rejected
TIMEOUT_US, 25000, time without an accepted pulse before a channel is declared lost (must be at most 65535)
FAILSAFE_VAL, 0, value driven on a lost channel

Ports:
us_clk  input  1  1 MHz clock; all logic on its rising edge
resetn  input  1  asynchronous active-low reset
pwm_in  input  NUM_CHANNELS  raw RC PWM pins, asynchronous to us_clk
val_out  output  NUM_CHANNELS*VAL_BIT_WIDTH  channel i in bits [i*W +: W]
channel_good  output  NUM_CHANNELS  1 = channel has an accepted pulse within TIMEOUT_US
all_good  output  1  AND of channel_good
update_strobe  output  NUM_CHANNELS  1-cycle pulse when channel i accepts a pulse
frame_strobe  output  1  1-cycle pulse when every channel has updated since the last frame_strobe

Behaviour:
- Reset (async assert, sync release by us_clk):
  - val_out = FAILSAFE_VAL on all channels.
  - channel_good, all_good, update_strobe, frame_strobe = 0.
  - All counters 0, all armed flags 0, frame-seen mask 0.
- Input path: each channel passes through a 2-flop synchroniser plus a history flop. Edges are detected from stage2 versus history.
- Per-channel FSM:
  - States: IDLE (unarmed), WAIT_RISE, MEASURE.
  - IDLE -> WAIT_RISE when the synchronised input is seen low. A pulse already in progress at reset release is never measured.
  - WAIT_RISE -> MEASURE on a rising edge; the width counter is loaded with 1.
  - MEASURE: the counter increments every cycle while high and saturates at 16'hFFFF.
  - MEASURE -> WAIT_RISE on a falling edge; the width is evaluated on that edge.
- Width = number of us_clk cycles the synchronised signal was high.
  - Width < GLITCH_MIN_US or > GLITCH_MAX_US: pulse rejected. No strobe, val_out unchanged, timeout not reset.
- Accepted pulse:
  - Clamp: c = max(width, MIN_PULSE_US).
  - Scale: v = (c - MIN_PULSE_US) >> SCALE_SHIFT, saturated to 2^W - 1.
  - val_out[i] is registered with v, update_strobe[i] = 1 for one cycle, timeout counter cleared, channel_good[i] = 1.
  - Timing: val_out and update_strobe[i] change 3 us_clk edges after the first edge that samples the pin low.
- Timeout:
  - Per-channel 16-bit counter increments each cycle and saturates.
  - When it reaches TIMEOUT_US: channel_good[i] = 0 and val_out[i] = FAILSAFE_VAL on the same edge. Both hold until the next accepted pulse.
  - An accepted pulse on the same cycle as the timeout threshold takes priority: the channel stays good with the new value.
- Frame tracking:
  - The seen mask sets bit i on update_strobe[i].
  - When the mask (including bits set this cycle) is all ones, frame_strobe pulses one cycle, registered together with the completing update_strobe, and the mask clears.
  - A channel timing out clears its seen bit.
  - Simultaneous updates on several channels are all counted.
- Reset mid-pulse: returns everything to reset values. Measurement resumes only after re-arm (low seen).
- all_good is registered and updates on the same edge as channel_good.

Test Plan:
- Reset release, then ch0 driven high 1500 us -> update_strobe[0] one cycle, val_out[7:0] = 125, channel_good[0] = 1.
- Pulses of 900 / 2000 / 2100 us on ch1 -> values 0 / 250 / 255 (clamp and saturate), strobe each time.
- ch2 700 us and ch2 2600 us pulses after a 1500 us pulse -> no strobe, value stays 125.
- All four channels pulsed 1500 us in staggered order -> single frame_strobe coincident with the last update_strobe; a further ch0 pulse gives no frame_strobe.
- ch3 pulses stop -> exactly 25000 cycles after its last accept, channel_good[3] = 0, all_good = 0, val_out[31:24] = 0; next valid pulse restores good and value.
- Assert resetn low mid-way through a 1500 us ch0 pulse, release while still high -> that pulse ignored, next full pulse measured correctly, outputs at failsafe meanwhile.
